// File: rtl/sram_like_responder.sv
// sram_like_responder: in-order, fixed-latency SRAM-like bus memory (req/addr_ok accept, data_ok/rdata/data_err completion)
module sram_like_responder #(
  parameter int DEPTH_LOG2 = 12,
  parameter int LATENCY = 2,
  parameter int QDEPTH = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata,
  output logic        data_err
);
  localparam int PW = QDEPTH > 1 ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH + 1);
  localparam int AW = DEPTH_LOG2 + 2;
  localparam logic [PW-1:0] LAST = PW'(QDEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(QDEPTH);
  localparam logic [2:0] LAT0 = 3'(LATENCY - 1);
  logic q_wr [QDEPTH];
  logic [1:0] q_size [QDEPTH];
  logic [AW-1:0] q_addr [QDEPTH];
  logic [31:0] q_wdata [QDEPTH];
  logic [2:0] q_rem [QDEPTH];
  logic [31:0] mem [2**DEPTH_LOG2];
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;
  logic run, accept, h_wr, h_err, commit;
  logic [1:0] h_size;
  logic [AW-1:0] h_addr;
  logic [31:0] h_wdata;
  logic [3:0] be;
  logic [DEPTH_LOG2-1:0] idx;
  logic unused_hi;
  assign unused_hi = ^addr[31:AW];
  always_comb begin
    h_wr = q_wr[head];
    h_size = q_size[head];
    h_addr = q_addr[head];
    h_wdata = q_wdata[head];
    addr_ok = run && count < FULL;
    accept = req && addr_ok;
    data_ok = count != '0 && q_rem[head] == 3'd0;
    h_err = h_size == 2'd3 || (h_size == 2'd1 && h_addr[0]) || (h_size == 2'd2 && h_addr[1:0] != 2'b00);
    idx = h_addr[AW-1:2];
    be = h_size == 2'd0 ? 4'b0001 << h_addr[1:0] : h_size == 2'd1 ? 4'b0011 << h_addr[1:0] : 4'hF;
    commit = data_ok && h_wr && !h_err;
    rdata = data_ok && !h_wr ? mem[idx] : 32'h0;
    data_err = data_ok && h_err;
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      run <= 1'b0;
      count <= '0;
      head <= '0;
      tail <= '0;
    end else begin
      run <= 1'b1;
      if (accept) tail <= tail == LAST ? '0 : tail + PW'(1);
      if (data_ok) head <= head == LAST ? '0 : head + PW'(1);
      count <= count + CW'(accept) - CW'(data_ok);
    end
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < QDEPTH; i++) q_rem[i] <= q_rem[i] != 3'd0 ? q_rem[i] - 3'd1 : 3'd0;
    if (accept) begin
      q_wr[tail] <= wr;
      q_size[tail] <= size;
      q_addr[tail] <= addr[AW-1:0];
      q_wdata[tail] <= wdata;
      q_rem[tail] <= LAT0;
    end
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (commit && be[i]) mem[idx][8*i +: 8] <= h_wdata[8*i +: 8];
  end
endmodule

// File: tb/tb_sram_like_responder.sv
// tb_sram_like_responder: table, directed and random checks of sram_like_responder against a timestamped transaction model
module tb_sram_like_responder;
  localparam int DL = 12, LAT = 2, QD = 2;
  logic clk = 0, resetn = 0, req = 0, wr = 0;
  logic [1:0] size = 0;
  logic [31:0] addr = 0, wdata = 0;
  logic addr_ok, data_ok, data_err;
  logic [31:0] rdata;
  sram_like_responder #(.DEPTH_LOG2(DL), .LATENCY(LAT), .QDEPTH(QD)) dut (
    .clk(clk), .resetn(resetn), .req(req), .wr(wr), .size(size), .addr(addr), .wdata(wdata),
    .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata), .data_err(data_err)
  );
  always #5 clk = ~clk;
  typedef struct {logic w; logic [1:0] s; logic [31:0] a; logic [31:0] d; int due;} txn_t;
  typedef struct {logic w; logic [1:0] s; logic [31:0] a; logic [31:0] d; logic [31:0] er; logic ee;} vec_t;
  txn_t q[$];
  logic [31:0] mm [int];
  logic [32:0] got[$];
  int nvec = 0, nerr = 0, cyc = 0, n_acc = 0, n_dok = 0, n_drop = 0;
  logic hi_edge = 0;
  task automatic chk(input string nm, input logic [63:0] g, input logic [63:0] e);
    nvec++;
    if (g !== e) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, g, e);
    end
  endtask
  function automatic logic misal(input logic [1:0] s, input logic [31:0] a);
    return s == 2'd3 || (s == 2'd1 && a[0]) || (s == 2'd2 && a[1:0] != 2'b00);
  endfunction
  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % (1 << DL));
  endfunction
  always @(posedge clk) begin
    cyc <= cyc + 1;
    hi_edge <= resetn;
  end
  always @(negedge clk) begin
    txn_t t;
    logic [31:0] w;
    int k;
    bit dv;
    if (!resetn) begin
      chk("reset_outputs", {addr_ok, data_ok, data_err, rdata}, 0);
      n_drop += q.size();
      q.delete();
    end else begin
      chk("addr_ok", addr_ok, hi_edge && q.size() < QD);
      dv = q.size() > 0 && q[0].due == cyc;
      chk("data_ok", data_ok, dv);
      if (data_ok) begin
        n_dok++;
        got.push_back({data_err, rdata});
      end
      if (!data_ok) chk("idle_outputs", {data_err, rdata}, 0);
      if (dv) begin
        t = q.pop_front();
        k = widx(t.a);
        chk("data_err", data_err, misal(t.s, t.a));
        if (t.w) chk("rdata_on_write", rdata, 0);
        else if (mm.exists(k) && !$isunknown(mm[k])) chk("rdata", rdata, mm[k]);
        if (t.w && !misal(t.s, t.a)) begin
          w = mm.exists(k) ? mm[k] : 32'hx;
          for (int b = int'(t.a[1:0]); b < int'(t.a[1:0]) + (1 << t.s); b++) w[8*b +: 8] = t.d[8*b +: 8];
          mm[k] = w;
        end
      end
      if (req && addr_ok) begin
        n_acc++;
        q.push_back('{wr, size, addr, wdata, cyc + LAT});
      end
    end
  end
  task automatic put(input logic w, input logic [1:0] s, input logic [31:0] a, input logic [31:0] d);
    bit ok = 0;
    req = 1; wr = w; size = s; addr = a; wdata = d;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      ok = addr_ok;
      @(posedge clk);
      #1;
    end
    req = 0;
    if (!ok) begin
      nvec++; nerr++;
      $display("FAIL put_timeout: addr_ok stayed 0, expected 1");
    end
  endtask
  task automatic drain();
    for (int i = 0; i < 40 && q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    if (q.size() != 0) begin
      nvec++; nerr++;
      $display("FAIL drain_timeout: %0d pending, expected 0", q.size());
    end
  endtask
  task automatic rd_chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    got.delete();
    put(0, 2'd2, a, 0);
    drain();
    chk({nm, "_count"}, got.size(), 1);
    if (got.size() == 1) chk(nm, got[0], {1'b0, e});
  endtask
  vec_t tv[16];
  logic [5:0] pat;
  logic [31:0] ba[5];
  logic [31:0] be_exp[5];
  initial begin
    bit ok;
    int k;
    tv[0]  = '{1, 2'd2, 32'h40,   32'hDEADBEEF, 32'h0,        0};
    tv[1]  = '{0, 2'd2, 32'h40,   32'h0,        32'hDEADBEEF, 0};
    tv[2]  = '{1, 2'd2, 32'h100,  32'h11223344, 32'h0,        0};
    tv[3]  = '{1, 2'd0, 32'h102,  32'h00AA0000, 32'h0,        0};
    tv[4]  = '{1, 2'd1, 32'h100,  32'h00005566, 32'h0,        0};
    tv[5]  = '{0, 2'd2, 32'h100,  32'h0,        32'h11AA5566, 0};
    tv[6]  = '{1, 2'd2, 32'h42,   32'hFFFFFFFF, 32'h0,        1};
    tv[7]  = '{0, 2'd2, 32'h40,   32'h0,        32'hDEADBEEF, 0};
    tv[8]  = '{0, 2'd1, 32'h41,   32'h0,        32'hDEADBEEF, 1};
    tv[9]  = '{0, 2'd3, 32'h40,   32'h0,        32'hDEADBEEF, 1};
    tv[10] = '{0, 2'd2, 32'h4040, 32'h0,        32'hDEADBEEF, 0};
    tv[11] = '{1, 2'd1, 32'h103,  32'h12345678, 32'h0,        1};
    tv[12] = '{1, 2'd0, 32'h103,  32'h77000000, 32'h0,        0};
    tv[13] = '{0, 2'd0, 32'h101,  32'h0,        32'h77AA5566, 0};
    tv[14] = '{1, 2'd1, 32'h102,  32'hBEEF0000, 32'h0,        0};
    tv[15] = '{0, 2'd2, 32'h100,  32'h0,        32'hBEEF5566, 0};
    req = 1; wr = 0; size = 2; addr = 32'h40;
    repeat (3) @(posedge clk);
    #1;
    resetn = 1; req = 0;
    for (int i = 0; i < 16; i++) begin
      got.delete();
      put(tv[i].w, tv[i].s, tv[i].a, tv[i].d);
      drain();
      chk($sformatf("vec%0d_count", i), got.size(), 1);
      if (got.size() == 1) chk($sformatf("vec%0d", i), got[0], {tv[i].ee, tv[i].er});
    end
    got.delete();
    put(1, 2'd2, 32'h80, 32'hCAFEF00D);
    put(0, 2'd2, 32'h80, 0);
    drain();
    chk("wr_rd_b2b_count", got.size(), 2);
    if (got.size() == 2) chk("wr_rd_b2b", got[1], {1'b0, 32'hCAFEF00D});
    pat = 6'b011011;
    ba = '{32'h40, 32'h100, 32'h80, 32'h40, 32'h100};
    be_exp = '{32'hDEADBEEF, 32'hBEEF5566, 32'hCAFEF00D, 32'hDEADBEEF, 32'hBEEF5566};
    got.delete();
    k = 0;
    req = 1; wr = 0; size = 2; addr = ba[0];
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("bp_addr_ok%0d", i), addr_ok, pat[i]);
      ok = addr_ok;
      @(posedge clk);
      #1;
      if (ok && k < 4) begin
        k++;
        addr = ba[k];
      end
    end
    put(0, 2'd2, ba[4], 0);
    drain();
    chk("bp_count", got.size(), 5);
    for (int i = 0; i < 5 && i < got.size(); i++) chk($sformatf("bp_rd%0d", i), got[i], {1'b0, be_exp[i]});
    put(1, 2'd2, 32'h300, 32'h01010101);
    put(1, 2'd2, 32'h304, 32'h02020202);
    drain();
    got.delete();
    put(1, 2'd2, 32'h300, 32'hAAAAAAAA);
    put(1, 2'd2, 32'h304, 32'hBBBBBBBB);
    resetn = 0;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1;
    chk("midflight_no_data_ok", got.size(), 0);
    rd_chk("midflight_rd0", 32'h300, 32'h01010101);
    rd_chk("midflight_rd1", 32'h304, 32'h02020202);
    for (int i = 0; i < 8; i++) put(1, 2'd2, 32'h200 + 4 * i, $urandom);
    drain();
    for (int i = 0; i < 300; i++) begin
      put(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
          32'h200 + $urandom_range(0, 31) + ($urandom_range(0, 3) << 14) + ($urandom_range(0, 1) << 31),
          $urandom);
      if ($urandom_range(0, 2) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    drain();
    chk("data_ok_total", n_dok, n_acc - n_drop);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
